// File: rtl/divider_unit_pkg.sv
// divider_unit_pkg: RV32M divide opcode encodings and divider FSM state, shared with the M-extension decoder.
package divider_unit_pkg;

   localparam int DIV_OP_WIDTH = 2;

   localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'd0;
   localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'd1;
   localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'd2;
   localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'd3;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_CALC,
      DIV_DONE,
      DIV_WAIT_LOW
   } div_state_e;

   function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? -v : v;
   endfunction

endpackage

// File: rtl/divider_unit.sv
// divider_unit: multi-cycle RV32M DIV/DIVU/REM/REMU unit, 32-step restoring division on magnitudes.
// Divide-by-zero and signed overflow bypass CALC and return the architecturally mandated results.
module divider_unit
   import divider_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [DIV_OP_WIDTH-1:0] DIVop,
   input  logic [XLEN-1:0]         dividend,
   input  logic [XLEN-1:0]         divisor,
   input  logic                    div_valid,
   output logic                    div_ready,
   output logic [XLEN-1:0]         div_result,
   output logic                    div_busy
);

   div_state_e      state, state_n;
   logic [XLEN-1:0] q, rem, b_mag, res;
   logic [4:0]      cnt;
   logic            is_rem, neg_q, neg_r;

   logic            in_signed, in_rem, div0, ovf, special;
   logic [XLEN-1:0] special_res;
   logic [XLEN:0]   rem_sh;
   logic            ge;
   logic [XLEN-1:0] rem_nx, q_nx, fixed_res;

   assign in_signed   = (DIVop == DIV_OP_DIV) || (DIVop == DIV_OP_REM);
   assign in_rem      = (DIVop == DIV_OP_REM) || (DIVop == DIV_OP_REMU);
   assign div0        = divisor == '0;
   assign ovf         = in_signed && dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF;
   assign special     = div0 || ovf;
   assign special_res = div0 ? (in_rem ? dividend : '1) : (in_rem ? '0 : 32'h8000_0000);

   // Shifted remainder needs a 33rd bit when |b| is near 2^32; the difference always fits in 32.
   assign rem_sh    = {rem, q[XLEN-1]};
   assign ge        = rem_sh >= {1'b0, b_mag};
   assign rem_nx    = ge ? rem_sh[XLEN-1:0] - b_mag : rem_sh[XLEN-1:0];
   assign q_nx      = {q[XLEN-2:0], ge};
   assign fixed_res = is_rem ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -q_nx : q_nx);

   assign div_busy = (state == DIV_CALC) || (state == DIV_DONE);

   always_comb begin
      state_n = state;
      case (state)
         DIV_IDLE:     if (div_valid) state_n = special ? DIV_DONE : DIV_CALC;
         DIV_CALC:     if (cnt == 5'd31) state_n = DIV_DONE;
         DIV_DONE:     state_n = DIV_WAIT_LOW;
         DIV_WAIT_LOW: if (!div_valid) state_n = DIV_IDLE;
         default:      state_n = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= DIV_IDLE;
         div_ready  <= 1'b0;
         div_result <= '0;
         q          <= '0;
         rem        <= '0;
         b_mag      <= '0;
         res        <= '0;
         cnt        <= '0;
         is_rem     <= 1'b0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
      end else begin
         state     <= state_n;
         div_ready <= state == DIV_DONE;
         if (state == DIV_DONE) div_result <= res;
         if (state == DIV_IDLE && div_valid) begin
            is_rem <= in_rem;
            neg_q  <= in_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r  <= in_signed && dividend[XLEN-1];
            b_mag  <= mag(divisor, in_signed);
            q      <= mag(dividend, in_signed);
            rem    <= '0;
            cnt    <= '0;
            if (special) res <= special_res;
         end else if (state == DIV_CALC) begin
            q   <= q_nx;
            rem <= rem_nx;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) res <= fixed_res;
         end
      end
   end

endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit: directed self-checking bench for divider_unit, checking results, ready latency and handshake.
module tb_divider_unit;
   import divider_unit_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [1:0]  DIVop = 2'd0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        div_valid = 1'b0;
   logic        div_ready;
   logic [31:0] div_result;
   logic        div_busy;

   int n_cmp = 0;
   int n_bad = 0;

   divider_unit #(.XLEN(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .DIVop      (DIVop),
      .dividend   (dividend),
      .divisor    (divisor),
      .div_valid  (div_valid),
      .div_ready  (div_ready),
      .div_result (div_result),
      .div_busy   (div_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one request, measures edges from accept to ready, checks result; optionally
   // scrambles the operands right after accept to prove they were latched.
   task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat, input bit scramble);
      int got;
      @(negedge clk);
      DIVop = op; dividend = a; divisor = b; div_valid = 1'b1;
      @(posedge clk);
      #1;
      if (scramble) begin
         dividend = 32'h0000_0005;
         divisor  = 32'h0000_0001;
      end
      got = 0;
      for (int i = 1; i <= 40 && got == 0; i++) begin
         @(posedge clk);
         #1;
         if (div_ready) got = i;
      end
      chk({tag, " latency"}, 32'(got), 32'(lat));
      chk({tag, " result"}, div_result, exp);
      @(posedge clk);
      #1;
      chk({tag, " ready pulse width"}, {31'd0, div_ready}, 32'd0);
      @(negedge clk);
      div_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
   endtask

   initial begin
      int extra;
      #1;
      chk("reset ready", {31'd0, div_ready}, 32'd0);
      chk("reset result", div_result, 32'd0);
      chk("reset busy", {31'd0, div_busy}, 32'd0);
      #12;
      @(negedge clk);
      resetn = 1'b1;

      run("divu 100/7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
      run("remu 100/7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);
      run("div -20/3", DIV_OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, 1'b0);
      run("rem -20/3", DIV_OP_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33, 1'b0);
      run("rem -7/2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
      run("rem 7/-2", DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
      run("div min/2", DIV_OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, 1'b0);
      run("divu max/max-1", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
      run("remu max/max-1", DIV_OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
      run("div 5/0", DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
      run("remu 5/0", DIV_OP_REMU, 32'd5, 32'd0, 32'd5, 1, 1'b0);
      run("rem ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
      run("div ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
      run("divu latched", DIV_OP_DIVU, 32'd1000, 32'd10, 32'd100, 33, 1'b1);

      // valid held long after the ready pulse must not restart the unit
      @(negedge clk);
      DIVop = DIV_OP_DIVU; dividend = 32'd50; divisor = 32'd5; div_valid = 1'b1;
      for (int i = 0; i < 34; i++) @(posedge clk);
      #1;
      chk("hold first ready", {31'd0, div_ready}, 32'd1);
      chk("hold result", div_result, 32'd10);
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (div_ready || div_busy) extra++;
      end
      chk("hold no restart", 32'(extra), 32'd0);
      chk("hold result kept", div_result, 32'd10);
      @(negedge clk);
      div_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      run("divu 9/3 after hold", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b0);

      // reset in the middle of CALC abandons the operation
      @(negedge clk);
      DIVop = DIV_OP_DIVU; dividend = 32'd77; divisor = 32'd7; div_valid = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 15; i++) @(posedge clk);
      #1;
      chk("busy in calc", {31'd0, div_busy}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("midreset ready", {31'd0, div_ready}, 32'd0);
      chk("midreset result", div_result, 32'd0);
      chk("midreset busy", {31'd0, div_busy}, 32'd0);
      div_valid = 1'b0;
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (div_ready) extra++;
      end
      chk("midreset no pulse", 32'(extra), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      run("divu max/1", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
